// File: rtl/fir_ch_sched.sv
// Two-channel round-robin scheduler for the shared folded FIR MAC datapath.
// Grants one sample at a time, sequences the MAC phases and holds the result until it is taken.
module fir_ch_sched #(
    parameter int unsigned N_PHASE = 4
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic [1:0]                 chan_en,
    input  logic [1:0]                 in_valid,
    output logic [1:0]                 in_ready,
    input  logic                       out_ready,
    output logic                       x_clr,
    output logic [1:0]                 shift,
    output logic                       ch_sel,
    output logic [$clog2(N_PHASE)-1:0] ctrl,
    output logic                       y_clr,
    output logic                       y_en,
    output logic                       out_valid,
    output logic                       out_ch,
    output logic                       busy
);

    localparam int unsigned CW = $clog2(N_PHASE);

    typedef enum logic [1:0] {StClr, StArb, StMac, StDone} state_e;

    state_e        state;
    logic [CW-1:0] cnt;
    logic          cur;
    logic          last;

    logic [1:0] req;
    logic       pri;
    logic       has_grant;
    logic       g;

    // In DONE the result being consumed already counts as served, so cur sets priority.
    always_comb begin
        req       = in_valid & chan_en;
        pri       = (state == StDone) ? cur : last;
        has_grant = (|req) && ((state == StArb) || ((state == StDone) && out_ready));
        g         = (req == 2'b11) ? ~pri : req[1];
    end

    always_comb begin
        in_ready  = 2'b00;
        shift     = 2'b00;
        x_clr     = 1'b0;
        ch_sel    = 1'b0;
        ctrl      = '0;
        y_clr     = 1'b0;
        y_en      = 1'b0;
        out_valid = 1'b0;
        out_ch    = 1'b0;
        busy      = 1'b0;
        unique case (state)
            StClr: x_clr = 1'b1;
            StArb: ;
            StMac: begin
                y_en   = 1'b1;
                ctrl   = cnt;
                ch_sel = cur;
                busy   = 1'b1;
            end
            StDone: begin
                out_valid = 1'b1;
                out_ch    = cur;
                ch_sel    = cur;
                busy      = 1'b1;
            end
        endcase
        if (has_grant) begin
            in_ready = g ? 2'b10 : 2'b01;
            shift    = g ? 2'b10 : 2'b01;
            y_clr    = 1'b1;
            ch_sel   = g;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= StClr;
            cnt   <= '0;
            cur   <= 1'b0;
            last  <= 1'b1;
        end else begin
            unique case (state)
                StClr: state <= StArb;
                StArb: begin
                    if (has_grant) begin
                        cur   <= g;
                        cnt   <= '0;
                        state <= StMac;
                    end
                end
                StMac: begin
                    cnt <= cnt + 1'b1;
                    if (cnt == CW'(N_PHASE - 1)) begin
                        state <= StDone;
                    end
                end
                StDone: begin
                    if (out_ready) begin
                        last <= cur;
                        if (has_grant) begin
                            cur   <= g;
                            cnt   <= '0;
                            state <= StMac;
                        end else begin
                            state <= StArb;
                        end
                    end
                end
            endcase
        end
    end

endmodule

// File: tb/tb_fir_ch_sched.sv
// Randomized bench for fir_ch_sched against a sample-level behavioural model.
module tb_fir_ch_sched;

    localparam int N = 4;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [1:0] chan_en = 2'b00;
    logic [1:0] in_valid = 2'b00;
    logic       out_ready = 1'b0;
    logic [1:0] in_ready, shift, ctrl;
    logic       x_clr, ch_sel, y_clr, y_en, out_valid, out_ch, busy;

    always #5 clk = ~clk;

    fir_ch_sched #(.N_PHASE(N)) dut (
        .clk      (clk),
        .rst      (rst),
        .chan_en  (chan_en),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .out_ready(out_ready),
        .x_clr    (x_clr),
        .shift    (shift),
        .ch_sel   (ch_sel),
        .ctrl     (ctrl),
        .y_clr    (y_clr),
        .y_en     (y_en),
        .out_valid(out_valid),
        .out_ch   (out_ch),
        .busy     (busy)
    );

    int n_total = 0;
    int n_bad   = 0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s at %0t: got %0h expected %0h", tag, $time, got, exp);
        end
    endtask

    // Model: pending clear cycle, MAC phases still to run, held result, channel, last served.
    bit m_clr;
    int m_left;
    bit m_done;
    bit m_ch;
    bit m_last;
    int n_acc[2];

    bit       e_grant;
    bit       e_g;
    bit [1:0] e_in_ready, e_ctrl;
    bit       e_x_clr, e_ch_sel, e_y_clr, e_y_en, e_out_valid, e_out_ch, e_busy;

    task automatic model_reset();
        m_clr  = 1'b1;
        m_left = 0;
        m_done = 1'b0;
        m_ch   = 1'b0;
        m_last = 1'b1;
    endtask

    task automatic model_eval();
        bit [1:0] req;
        bit       prio;
        e_grant = 0; e_g = 0; e_in_ready = 0; e_ctrl = 0; e_x_clr = 0; e_ch_sel = 0;
        e_y_clr = 0; e_y_en = 0; e_out_valid = 0; e_out_ch = 0; e_busy = 0;
        if (rst || m_clr) begin
            e_x_clr = 1;
        end else if (m_left > 0) begin
            e_y_en   = 1;
            e_ctrl   = 2'(N - m_left);
            e_ch_sel = m_ch;
            e_busy   = 1;
        end else begin
            req  = in_valid & chan_en;
            prio = m_done ? m_ch : m_last;
            if (m_done) begin
                e_out_valid = 1;
                e_out_ch    = m_ch;
                e_ch_sel    = m_ch;
                e_busy      = 1;
            end
            if (req != 2'b00 && (!m_done || out_ready)) begin
                e_grant    = 1;
                e_g        = (req == 2'b11) ? !prio : (req == 2'b10);
                e_in_ready = e_g ? 2'b10 : 2'b01;
                e_y_clr    = 1;
                e_ch_sel   = e_g;
            end
        end
    endtask

    task automatic model_step();
        if (rst) begin
            model_reset();
        end else if (m_clr) begin
            m_clr = 0;
        end else if (m_left > 0) begin
            m_left--;
            if (m_left == 0) m_done = 1;
        end else begin
            if (m_done && out_ready) begin
                m_last = m_ch;
                m_done = 0;
            end
            if (e_grant) begin
                m_ch   = e_g;
                m_left = N;
                m_done = 0;
                n_acc[e_g]++;
            end
        end
    endtask

    // Segments: idle after reset, single requests, contention, backpressure, ch0 disabled, random.
    int seg_len[6] = '{10, 40, 40, 80, 40, 2500};
    int seg_en[6]  = '{3, 3, 3, 3, 2, 4};
    int seg_iv[6]  = '{0, 5, 3, 3, 3, 4};
    int seg_or[6]  = '{100, 100, 100, 15, 100, 70};
    int seg_rst[6] = '{0, 0, 0, 0, 0, 2};

    initial begin
        int cyc;
        int r;
        int acc0_before;
        cyc = 0;
        acc0_before = 0;
        n_acc[0] = 0;
        n_acc[1] = 0;
        model_reset();
        @(posedge clk);
        #1;
        for (int s = 0; s < 6; s++) begin
            if (s == 4) acc0_before = n_acc[0];
            for (int i = 0; i < seg_len[s]; i++) begin
                rst = (cyc < 3) || ($urandom_range(0, 99) < seg_rst[s]);
                if (seg_en[s] == 4) begin
                    r = $urandom_range(0, 7);
                    chan_en = (r < 4) ? 2'b11 : 2'(r);
                end else begin
                    chan_en = 2'(seg_en[s]);
                end
                if (seg_iv[s] == 4)      in_valid = 2'($urandom_range(0, 3));
                else if (seg_iv[s] == 5) in_valid = 2'($urandom_range(0, 2));
                else                     in_valid = 2'(seg_iv[s]);
                out_ready = ($urandom_range(0, 99) < seg_or[s]);

                @(negedge clk);
                model_eval();
                check_eq("in_ready", 32'(in_ready), 32'(e_in_ready));
                check_eq("shift", 32'(shift), 32'(e_in_ready));
                check_eq("x_clr", 32'(x_clr), 32'(e_x_clr));
                check_eq("ch_sel", 32'(ch_sel), 32'(e_ch_sel));
                check_eq("ctrl", 32'(ctrl), 32'(e_ctrl));
                check_eq("y_clr", 32'(y_clr), 32'(e_y_clr));
                check_eq("y_en", 32'(y_en), 32'(e_y_en));
                check_eq("out_valid", 32'(out_valid), 32'(e_out_valid));
                if (e_out_valid) check_eq("out_ch", 32'(out_ch), 32'(e_out_ch));
                check_eq("busy", 32'(busy), 32'(e_busy));

                @(posedge clk);
                model_step();
                #1;
                cyc++;
            end
            if (s == 4) check_eq("no_ch0_grant_while_disabled", 32'(n_acc[0]), 32'(acc0_before));
        end
        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
